// File: rtl/dmem_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the
// single-ported data memory.
interface dmem_if #(
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [31:0]       addr0;
  logic [31:0]       addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              lock1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic              rerr0;
  logic              rerr1;
  logic [DATA_W-1:0] rdata;
  logic              stall0;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, rdata, stall0,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, rdata, stall0,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded port-1 burst lock for the shared data
// memory; drives the memory port and returns registered responses.
module dmem_arbiter #(
  parameter int DEPTH    = 1024,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE, RR, LOCK} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last;
  logic            last_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            blk;
  logic            blk_nxt;
  logic            g0;
  logic            g1;
  logic            sel_we;
  logic [31:0]     sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic            in_range;
  logic            any_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      blk   <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      blk   <= blk_nxt;
    end
  end

  // cnt holds the number of locked grants already issued in the current burst;
  // the grant that brings it to MAX_LOCK is the last one before a forced release.
  always_comb begin
    g0        = 1'b0;
    g1        = 1'b0;
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    blk_nxt   = 1'b0;
    if (state == LOCK) begin
      g1 = bus.req1 & bus.lock1;
      if (g1) begin
        cnt_nxt = cnt + CW'(1);
        if (cnt_nxt == CW'(MAX_LOCK)) begin
          state_nxt = RR;
          cnt_nxt   = '0;
          last_nxt  = 1'b1;
          blk_nxt   = 1'b1;
        end
      end else begin
        state_nxt = RR;
        cnt_nxt   = '0;
        last_nxt  = 1'b1;
      end
    end else begin
      if (bus.req0 && bus.req1) begin
        g0 = last;
        g1 = ~last;
      end else begin
        g0 = bus.req0;
        g1 = bus.req1;
      end
      if (g1 && bus.lock1 && !(blk && bus.req0)) begin
        state_nxt = LOCK;
        cnt_nxt   = CW'(1);
      end else if (g0 || g1) begin
        state_nxt = RR;
      end else begin
        state_nxt = IDLE;
      end
      if (g0) last_nxt = 1'b0;
      if (g1) last_nxt = 1'b1;
    end
  end

  // Grants are forced low while reset is held so nothing reaches the memory.
  assign bus.gnt0   = g0 & ~rst;
  assign bus.gnt1   = g1 & ~rst;
  assign bus.stall0 = bus.req0 & ~bus.gnt0;
  assign any_gnt    = bus.gnt0 | bus.gnt1;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (bus.gnt0) begin
      sel_we    = bus.we0;
      sel_addr  = bus.addr0;
      sel_wdata = bus.wdata0;
    end else if (bus.gnt1) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

  assign in_range      = sel_addr < 32'(DEPTH);
  assign bus.mem_we    = any_gnt & sel_we & in_range;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  // Writes and out-of-range accesses acknowledge with zero data; idle cycles
  // leave rdata untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      bus.rerr0   <= 1'b0;
      bus.rerr1   <= 1'b0;
      bus.rdata   <= '0;
    end else begin
      bus.rvalid0 <= bus.gnt0;
      bus.rvalid1 <= bus.gnt1;
      bus.rerr0   <= bus.gnt0 & ~in_range;
      bus.rerr1   <= bus.gnt1 & ~in_range;
      if (any_gnt) begin
        bus.rdata <= (in_range && !sel_we) ? bus.mem_rdata : '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural arbitration/memory model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;
  localparam int DEPTH    = 1024;
  localparam int DATA_W   = 32;
  localparam int MAX_LOCK = 16;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  dmem_if #(.DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // The physical memory: 10 address bits, synchronous write, combinational read.
  logic [DATA_W-1:0] env_mem [DEPTH];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) env_mem[i] <= '0;
    end else if (bus.mem_we) begin
      env_mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = env_mem[bus.mem_addr[9:0]];

  // Model state: who was served last, whether port 1 holds a burst and how many
  // burst grants it has had, and the one-cycle re-lock block after a forced release.
  int          m_last   = 1;
  bit          m_locked = 1'b0;
  int          m_burst  = 0;
  bit          m_blk    = 1'b0;
  logic [31:0] ref_mem [DEPTH];
  logic        exp_rv0 = 1'b0;
  logic        exp_rv1 = 1'b0;
  logic        exp_re0 = 1'b0;
  logic        exp_re1 = 1'b0;
  logic [31:0] exp_rdata = '0;

  function automatic logic [1:0] model_grant();
    logic [1:0] g;
    g = 2'b00;
    if (m_locked) begin
      g[1] = bus.req1 & bus.lock1;
    end else if (bus.req0 && bus.req1) begin
      if (m_last == 1) g[0] = 1'b1;
      else             g[1] = 1'b1;
    end else begin
      g[0] = bus.req0;
      g[1] = bus.req1;
    end
    return g;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [1:0]  g;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    bit          inr;
    bit          new_blk;
    if (rst) begin
      m_last    = 1;
      m_locked  = 1'b0;
      m_burst   = 0;
      m_blk     = 1'b0;
      exp_rv0   = 1'b0;
      exp_rv1   = 1'b0;
      exp_re0   = 1'b0;
      exp_re1   = 1'b0;
      exp_rdata = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      g   = model_grant();
      w   = g[0] ? bus.we0   : bus.we1;
      a   = g[0] ? bus.addr0 : bus.addr1;
      d   = g[0] ? bus.wdata0 : bus.wdata1;
      inr = (a < DEPTH);
      exp_rv0 = g[0];
      exp_rv1 = g[1];
      exp_re0 = g[0] & !inr;
      exp_re1 = g[1] & !inr;
      if (g != 2'b00) begin
        exp_rdata = (inr && !w) ? ref_mem[a[9:0]] : '0;
        if (w && inr) ref_mem[a[9:0]] = d;
      end
      new_blk = 1'b0;
      if (m_locked) begin
        if (g[1]) begin
          m_burst++;
          if (m_burst == MAX_LOCK) begin
            m_locked = 1'b0;
            m_burst  = 0;
            m_last   = 1;
            new_blk  = 1'b1;
          end
        end else begin
          m_locked = 1'b0;
          m_burst  = 0;
          m_last   = 1;
        end
      end else begin
        if (g[1] && bus.lock1 && !(m_blk && bus.req0)) begin
          m_locked = 1'b1;
          m_burst  = 1;
        end
        if (g[0]) m_last = 0;
        if (g[1]) m_last = 1;
      end
      m_blk = new_blk;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [1:0]  g;
    logic [31:0] ea;
    logic [31:0] ed;
    logic        ew;
    g  = rst ? 2'b00 : model_grant();
    ea = g[0] ? bus.addr0 : (g[1] ? bus.addr1 : 32'd0);
    ed = g[0] ? bus.wdata0 : (g[1] ? bus.wdata1 : 32'd0);
    ew = (g[0] & bus.we0) | (g[1] & bus.we1);
    ew = ew & (ea < DEPTH);
    checkOutput("gnt0", bus.gnt0, g[0]);
    checkOutput("gnt1", bus.gnt1, g[1]);
    checkOutput("stall0", bus.stall0, bus.req0 & ~g[0]);
    checkOutput("mem_we", bus.mem_we, ew);
    checkOutput("mem_addr", bus.mem_addr, ea);
    checkOutput("mem_wdata", bus.mem_wdata, ed);
    checkOutput("rvalid0", bus.rvalid0, exp_rv0);
    checkOutput("rvalid1", bus.rvalid1, exp_rv1);
    checkOutput("rerr0", bus.rerr0, exp_re0);
    checkOutput("rerr1", bus.rerr1, exp_re1);
    checkOutput("rdata", bus.rdata, exp_rdata);
  end

  // Drive one cycle of requests just after the rising edge, return at the
  // falling edge so the caller can inspect that cycle.
  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0,
                               input logic [31:0] d0, input logic r1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1, input logic l1);
    @(posedge clk);
    #1;
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    bus.lock1 = l1;
    @(negedge clk);
  endtask

  task automatic setIdle();
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    bus.lock1 = 0;
  endtask

  initial begin
    rst = 1'b1;
    setIdle();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    @(negedge clk);
    checkOutput("rst_gnt0", bus.gnt0, 0);
    checkOutput("rst_gnt1", bus.gnt1, 0);
    checkOutput("rst_rdata", bus.rdata, 0);
    setIdle();
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] contention after reset");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 1, 0, 1, 0, 2, 0, 0);
      checkOutput($sformatf("cont%0d_gnt0", i), bus.gnt0, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("cont%0d_gnt1", i), bus.gnt1, (i % 2 == 1) ? 1 : 0);
    end

    $display("[TB] single read");
    applyStimulus(0, 0, 0, 0, 1, 1, 32, 32'h5555_5555, 0);
    applyStimulus(1, 0, 32, 0, 0, 0, 0, 0, 0);
    checkOutput("rd32_gnt0", bus.gnt0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd32_rvalid0", bus.rvalid0, 1);
    checkOutput("rd32_rdata", bus.rdata, 32'h5555_5555);
    checkOutput("rd32_rerr0", bus.rerr0, 0);

    $display("[TB] write then read");
    applyStimulus(0, 0, 0, 0, 1, 1, 5, 32'hDEAD_BEEF, 0);
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("wr5_ack_rvalid1", bus.rvalid1, 1);
    checkOutput("wr5_ack_rdata", bus.rdata, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd5_rdata", bus.rdata, 32'hDEAD_BEEF);

    $display("[TB] out of range");
    applyStimulus(1, 1, 0, 32'h0BAD_F00D, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1024, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    checkOutput("oor_mem_we", bus.mem_we, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("oor_rvalid0", bus.rvalid0, 1);
    checkOutput("oor_rerr0", bus.rerr0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("oor_rd0_rdata", bus.rdata, 32'h0BAD_F00D);
    checkOutput("oor_rd0_rerr0", bus.rerr0, 0);

    $display("[TB] locked burst");
    for (int i = 0; i <= MAX_LOCK; i++) begin
      applyStimulus(1, 0, 7, 0, 1, 1, 200 + i, i, 1);
      if (i < MAX_LOCK) begin
        checkOutput($sformatf("burst%0d_gnt1", i), bus.gnt1, 1);
        checkOutput($sformatf("burst%0d_stall0", i), bus.stall0, 1);
      end else begin
        checkOutput("burst_end_gnt0", bus.gnt0, 1);
      end
    end

    $display("[TB] lock released by lock1");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 1, 400 + i, i, 1);
    applyStimulus(1, 0, 200, 0, 1, 1, 410, 0, 0);
    checkOutput("unlock_gnt0", bus.gnt0, 0);
    checkOutput("unlock_gnt1", bus.gnt1, 0);
    applyStimulus(1, 0, 200, 0, 1, 1, 410, 0, 0);
    checkOutput("after_unlock_gnt0", bus.gnt0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("after_unlock_rdata", bus.rdata, 0);

    $display("[TB] reset mid-burst");
    applyStimulus(0, 0, 0, 0, 1, 1, 300, 32'hAAAA_0000, 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 301, 32'hAAAA_0001, 1);
    checkOutput("pre_rst_gnt1", bus.gnt1, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_gnt0", bus.gnt0, 0);
    checkOutput("midrst_gnt1", bus.gnt1, 0);
    checkOutput("midrst_mem_we", bus.mem_we, 0);
    checkOutput("midrst_rvalid1", bus.rvalid1, 0);
    checkOutput("midrst_rdata", bus.rdata, 0);
    setIdle();
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1, 0, 5, 0, 1, 0, 6, 0, 0);
    checkOutput("postrst_gnt0", bus.gnt0, 1);
    applyStimulus(1, 0, 5, 0, 1, 0, 6, 0, 0);
    checkOutput("postrst_gnt1", bus.gnt1, 1);
    checkOutput("postrst_rdata", bus.rdata, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-ported 1024×32 data memory. Shares the memory between port 0 (pipeline MEM stage) and port 1 (debug/loader DMA). It grants at most one access per cycle, with round-robin fairness and a bounded lock for port-1 bursts. It drives the memory's synchronous-write, combinational-read port and returns registered read data with a valid strobe and an out-of-range error flag.

## Interface
- DEPTH, 1024: memory depth in words; valid word addresses are 0..DEPTH-1.
- DATA_W, 32: data width.
- MAX_LOCK, 16: maximum consecutive locked port-1 grants before a forced release.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req0, req1  in  1  access request, held until granted.
- we0, we1  in  1  1 = write, 0 = read; qualified by reqN.
- addr0, addr1  in  32  word address.
- wdata0, wdata1  in  DATA_W  write data.
- lock1  in  1  port-1 burst lock request.
- gnt0, gnt1  out  1  combinational; access accepted this cycle; one-hot or zero.
- rvalid0, rvalid1  out  1  registered; response for the access granted in the previous cycle.
- rerr0, rerr1  out  1  registered; the previous granted access was out of range.
- rdata  out  DATA_W  registered read data, shared; qualified by rvalidN.
- stall0  out  1  req0 & ~gnt0, the pipeline hazard-unit stall.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  combinational memory read data.

## Operation
- States: IDLE, RR, LOCK.
  - IDLE: no access last cycle.
  - RR: normal round-robin.
  - LOCK: port 1 holds the resource.
- Round-robin pointer `last`: reset value 1, so port 0 wins the first contention.
  - If only one port requests, that port is granted.
  - If both request, the port ≠ `last` is granted.
  - `last` updates to the granted port at each clock edge with a grant.
- LOCK entry: a port-1 grant with lock1=1 while not in LOCK. The lock counter loads 1.
- In LOCK:
  - gnt1 = req1 & lock1, regardless of req0; each grant increments the counter.
  - Exit to RR when lock1=0 or req1=0. Port 0 then gets priority: `last` is forced to 1.
  - Exit to RR when counter = MAX_LOCK. That cycle's port-1 grant is still issued. `last` is forced to 1, and lock re-entry is blocked for one cycle whenever req0=1, so port 0 is served next.
- Memory drive:
  - mem_addr and mem_wdata come from the granted port. With no grant, both are 0.
  - mem_we = gnt & we & in_range, where in_range = (addr < DEPTH).
  - Out-of-range writes are suppressed.
- Response: at the edge after a grant:
  - rvalidN = 1 for the granted port.
  - rerrN = ~in_range.
  - rdata = in_range & ~we ? mem_rdata : 0.
  - Writes also produce rvalidN = 1 with rdata = 0 as an acknowledge.
  - With no grant, rvalid and rerr are 0 and rdata holds its previous value.
- Reset (asynchronous, any cycle):
  - state = IDLE, last = 1, counter = 0.
  - rvalid0/1 = 0, rerr0/1 = 0, rdata = 0.
  - gnt0/1 = 0 and mem_we = 0 while rst is high.
  - An in-flight write on the reset edge is not performed; the memory also clears on the same reset.

## Timing
- Grant: same cycle as the request (0-cycle arbitration latency).
- Write commits at the clock edge ending the grant cycle.
- Read data: rvalid one cycle after the grant, stable for exactly one cycle.
- Throughput: one access per cycle in aggregate.
- A requester whose reqN stays high is re-evaluated every cycle. Back-to-back grants to the same port are allowed when the other port is idle.
- Worst-case port-0 wait: 1 cycle unlocked; MAX_LOCK cycles during a port-1 lock.

## Test plan
- Single read: memory word 32 = 0x55555555, req0 with addr0=32, we0=0 → gnt0 same cycle; next cycle rvalid0=1, rdata=0x55555555, rerr0=0.
- Contention after reset: req0 and req1 both high for 4 cycles → grants in the order 0, 1, 0, 1; no cycle with gnt0 & gnt1.
- Write then read: port 1 writes 0xDEADBEEF to addr 5; next cycle port 0 reads addr 5 → rdata=0xDEADBEEF; the write's ack cycle shows rvalid1=1 with rdata=0.
- Locked burst: req1 = lock1 = 1 continuously with req0 = 1, MAX_LOCK=16 → 16 consecutive gnt1, then gnt0; stall0 = 1 throughout the locked span.
- Out of range: port 0 writes addr 1024 → mem_we = 0, next cycle rvalid0 = rerr0 = 1; a following read of addr 0 returns its unchanged value.
- Reset mid-burst: assert rst during LOCK with a write granted → gnt0/1, rvalid and rdata are 0 immediately. After release, contention grants port 0 first.
